// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload and a clk_in-domain tick.
// Optional CLK_DIVIDER_ODD_DUTY50_EN: 50% duty for odd divisors via a negedge-clk_in flop.
`timescale 1ns/1ps
module clk_divider_prog #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_pend,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DEF_N   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);

    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   hi;
    logic [WIDTH:0]   cnt_inc;
    logic             wrap;
    logic             load_ok;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= DEF_N;
            cnt_q    <= DEF_CNT;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            pos_q    <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            pos_q    <= pos_d;
            tick_q   <= tick_d;
            err_q    <= err_d;
        end
    end

    // Period counter, phase decision and boundary-aligned divisor swap
    always_comb begin
`ifdef CLK_DIVIDER_ODD_DUTY50_EN
        hi = {2'b00, n_q[WIDTH-1:1]};
`else
        hi = {1'b0, n_q} - {2'b00, n_q[WIDTH-1:1]};
`endif
        cnt_inc  = {1'b0, cnt_q} + (WIDTH+1)'(1);
        wrap     = en && (cnt_q == (n_q - WIDTH'(1)));
        load_ok  = div_load && (div_val >= WIDTH'(2));

        n_d      = n_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        pos_d    = pos_q;
        tick_d   = 1'b0;
        err_d    = div_load && !load_ok;

        if (wrap) begin
            cnt_d  = '0;
            pos_d  = 1'b1;
            tick_d = 1'b1;
            // Only a value pending before this edge is eligible for adoption
            if (pend_v_q) begin
                n_d      = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
            pos_d = (cnt_inc < hi);
        end

        if (load_ok) begin
            pend_d   = div_val;
            pend_v_d = 1'b1;
        end
    end

`ifdef CLK_DIVIDER_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle stretch of the high phase, only for odd divisors
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q & n_q[0];
        end
    end

    assign clk_out = pos_q | neg_q;
`else
    assign clk_out = pos_q;
`endif

    assign tick      = tick_q;
    assign load_pend = pend_v_q;
    assign div_err   = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: vector table, directed corner sequences, random vs period model.
`timescale 1ns/1ps
module tb_clk_divider_prog;

    localparam int unsigned W = 16;

    logic         clk_in = 1'b0;
    logic         rst_n;
    logic         en;
    logic         div_load;
    logic [W-1:0] div_val;
    logic         clk_out;
    logic         tick;
    logic         load_pend;
    logic         div_err;

    int checks = 0;
    int errors = 0;

    clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(10)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .tick      (tick),
        .load_pend (load_pend),
        .div_err   (div_err)
    );

    always #5 clk_in = ~clk_in;

    // Reference: position inside the current output period (0 = rising edge)
    int m_n, m_pos, m_pend;
    bit m_pend_v, m_tick, m_err, m_hi, m_neg, m_clk;

    function automatic int hi_of(input int n);
`ifdef CLK_DIVIDER_ODD_DUTY50_EN
        return n / 2;
`else
        return n - n / 2;
`endif
    endfunction

    function automatic void model_reset();
        m_n = 10; m_pos = 9; m_pend = 0; m_pend_v = 0;
        m_tick = 0; m_err = 0; m_hi = 0; m_neg = 0; m_clk = 0;
    endfunction

    function automatic void model_edge(input bit e, input bit ld, input int v);
        bit applied;
        applied = 0;
        m_neg   = m_hi && (m_n % 2 == 1);
        m_tick  = 0;
        if (e) begin
            if (m_pos == m_n - 1) begin
                m_pos  = 0;
                m_tick = 1;
                if (m_pend_v) begin
                    m_n = m_pend;
                    applied = 1;
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end
        if (applied) m_pend_v = 0;
        m_err = ld && (v < 2);
        if (ld && v >= 2) begin
            m_pend   = v;
            m_pend_v = 1;
        end
        m_hi = (m_pos < hi_of(m_n));
`ifdef CLK_DIVIDER_ODD_DUTY50_EN
        m_clk = m_hi | m_neg;
`else
        m_clk = m_hi;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_edge(input bit e, input bit ld, input int v);
        en = e; div_load = ld; div_val = W'(v);
        @(posedge clk_in);
        model_edge(e, ld, v);
        #1;
    endtask

    task automatic step(input bit e, input bit ld, input int v);
        drive_edge(e, ld, v);
        check("m_clk_out",   clk_out,   m_clk);
        check("m_tick",      tick,      m_tick);
        check("m_load_pend", load_pend, m_pend_v);
        check("m_div_err",   div_err,   m_err);
    endtask

    // Wait for the next tick, then count cycles until the following one
    task automatic measure_period(input int exp, input string name);
        int c;
        c = 0;
        do begin
            step(1, 0, 0);
            c++;
        end while (tick !== 1'b1 && c < 200);
        if (c >= 200) check({name, "_timeout"}, 0, 1);
        c = 0;
        do begin
            step(1, 0, 0);
            c++;
        end while (tick !== 1'b1 && c < 70000);
        check(name, c, exp);
    endtask

    typedef struct {
        bit          en;
        bit          ld;
        int          val;
        bit          clk;
        bit          tk;
        bit          pend;
        bit          err;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int hc, ft, fc;
        bit clk_before;

        // en, ld, val, clk_out, tick, load_pend, div_err
        tbl[0]  = '{1, 0, 0, 1, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 6, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 1, 0};
        tbl[11] = '{1, 0, 0, 1, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[17] = '{1, 0, 0, 1, 1, 0, 0};

        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
        model_reset();
        #12;
        check("rst_clk_out",   clk_out,   0);
        check("rst_tick",      tick,      0);
        check("rst_load_pend", load_pend, 0);
        check("rst_div_err",   div_err,   0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive_edge(tbl[i].en, tbl[i].ld, tbl[i].val);
            check($sformatf("tbl%0d_clk_out", i),   clk_out,   tbl[i].clk);
            check($sformatf("tbl%0d_tick", i),      tick,      tbl[i].tk);
            check($sformatf("tbl%0d_load_pend", i), load_pend, tbl[i].pend);
            check($sformatf("tbl%0d_div_err", i),   div_err,   tbl[i].err);
        end

        // Back to N=10, then rejected loads leave it untouched
        step(1, 1, 10);
        measure_period(10, "period_n10");
        step(1, 1, 1);
        check("err_val1", div_err, 1);
        step(1, 1, 0);
        check("err_val0", div_err, 1);
        step(1, 0, 0);
        check("err_cleared", div_err, 0);
        check("err_no_pend", load_pend, 0);
        measure_period(10, "period_after_err");

        // Mid-period load of 3: pending held until the boundary
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(1, 1, 3);
        check("pend_set", load_pend, 1);
        hc = 0;
        while (tick !== 1'b1 && hc < 20) begin
            step(1, 0, 0);
            hc++;
            if (tick !== 1'b1) check("pend_hold", load_pend, 1);
        end
        check("pend_clear_at_wrap", load_pend, 0);
        hc = 1;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0);
            if (clk_out === 1'b1) hc++;
        end
        check("n3_high_samples", hc, 2);
        step(1, 0, 0);
        check("n3_tick", tick, 1);
        measure_period(3, "period_n3");

        // Last write wins: 7 is overwritten by 4 before the wrap
        step(1, 1, 7);
        step(1, 1, 4);
        measure_period(4, "period_n4_a");
        measure_period(4, "period_n4_b");

        // Freeze mid-high-phase for 23 cycles
        step(1, 1, 10);
        measure_period(10, "period_n10_b");
        step(1, 0, 0);
        step(1, 0, 0);
        clk_before = clk_out;
        ft = 0; fc = 0;
        for (int i = 0; i < 23; i++) begin
            step(0, 0, 0);
            if (tick === 1'b1) ft++;
            if (clk_out !== clk_before) fc++;
        end
        check("freeze_ticks", ft, 0);
        check("freeze_clk_changes", fc, 0);
        check("freeze_clk_high", clk_before, 1);
        hc = 0;
        step(1, 0, 0);
        while (clk_out === 1'b1 && hc < 20) begin
            hc++;
            step(1, 0, 0);
        end
        check("resume_high_remaining", hc, 2);

        // Async reset mid-period with a huge divisor and something pending
        step(1, 1, 65535);
        hc = 0;
        do begin
            step(1, 0, 0);
            hc++;
        end while (tick !== 1'b1 && hc < 20);
        check("n65535_applied_tick", tick, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 0);
        step(1, 1, 5);
        check("big_pend_set", load_pend, 1);
        check("big_clk_high", clk_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_clk_out", clk_out, 0);
        check("async_rst_load_pend", load_pend, 0);
        check("async_rst_tick", tick, 0);
        #3;
        rst_n = 1'b1;
        step(1, 0, 0);
        check("first_tick_after_rst", tick, 1);
        hc = 0;
        do begin
            step(1, 0, 0);
            hc++;
        end while (tick !== 1'b1 && hc < 200);
        check("period_after_rst", hc, 10);

        // Random traffic against the period model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 12)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
- Runtime-programmable integer clock divider. Successor to the fixed-DIV divider.
- Divides clk_in by any N >= 2 held in a WIDTH-bit register and supports an enable.
- Divisor changes are glitch-free: they take effect only at a period boundary.
- Emits a one-cycle tick (clk_in domain) at each output rising edge, for logic that must stay synchronous to clk_in.

Parameters:
- WIDTH, 16, width of divisor register and counter.
- DEFAULT_DIV, 10, divisor loaded at reset; must be >= 2 and < 2^WIDTH.

Ports:
- clk_in  input  1  source clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; when low, the divider freezes.
- div_val  input  WIDTH  requested divisor N.
- div_load  input  1  one-cycle strobe; requests div_val be adopted.
- clk_out  output  1  divided clock, period N clk_in cycles.
- tick  output  1  one clk_in cycle high on the edge where clk_out rises.
- load_pend  output  1  accepted divisor waiting for the next boundary.
- div_err  output  1  one-cycle pulse: a div_load was rejected.

Behaviour:
- Interface: one clock, clk_in; reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk_in.
- Reset values (async on rst_n=0):
  - active divisor N = DEFAULT_DIV; cnt = DEFAULT_DIV-1.
  - clk_out=0, tick=0, load_pend=0, div_err=0; pending register cleared.
- High-phase length: HI = N - floor(N/2), i.e. ceil(N/2). Low phase = floor(N/2).
- Each edge with en=1:
  - If cnt==N-1 (wrap): cnt<=0, clk_out<=1, tick<=1.
  - Else: cnt<=cnt+1, clk_out<=(cnt+1 < HI), tick<=0.
- First enabled edge after reset release produces a clk_out rise plus a tick.
- en=0: cnt and clk_out hold their value, tick=0. Loads are still accepted into pending.
- Divisor load, on an edge with div_load=1:
  - div_val >= 2: pending<=div_val, load_pend<=1. A new load while pending overwrites the pending value; last write wins.
  - div_val < 2: pending unchanged; div_err=1 for exactly one cycle.
- Pending apply:
  - At the first wrap edge strictly after the load edge: N<=pending, load_pend<=0. New HI is used from the next edge.
  - A load on a wrap edge is applied at the following wrap.
  - Load and apply on the same edge: the old pending value is applied, the new one becomes pending, and load_pend stays 1.
- Arithmetic: cnt is WIDTH bits and never exceeds N-1. Compare cnt+1 at WIDTH+1 bits; no overflow for N = 2^WIDTH-1.
- Reset mid-period: clk_out drops immediately and all state returns to reset values. The shortened output pulse is accepted.
- Latency: div_load -> new period starts at most N_old clk_in cycles later.

Optional Feature:
- Macro: CLK_DIVIDER_ODD_DUTY50_EN.
- Defined:
  - For odd N, the posedge phase register uses HI=floor(N/2).
  - A negedge-clk_in flop copies it, and clk_out = pos | neg.
  - Result: high exactly N/2 clk_in periods, i.e. 50% duty. Rise stays aligned to a clk_in posedge; tick is unchanged.
  - Even N behaves identically to the undefined case.
  - The negedge flop resets to 0 on rst_n.
- Undefined: no negedge logic; odd N gives ceil(N/2) high and floor(N/2) low.

Test Plan:
- Reset, en=1, no load, 1 kHz clk_in -> clk_out period 10 ms, 5 high/5 low, tick every 10 cycles; first rise on first edge after reset release.
- div_val=3 loaded mid-period with N=10 -> load_pend=1 until wrap. Then period 3: high 2/low 1 without the macro, high 1.5/low 1.5 with it. No output pulse shorter than min(old, new) phase.
- div_load with div_val=1, then with div_val=0 -> div_err pulses 1 cycle each; N stays 10; load_pend stays 0.
- Two loads (7 then 4) before one wrap -> only 4 is adopted; the 7-cycle period never appears.
- en=0 for 23 cycles mid-high-phase -> clk_out and cnt frozen, no ticks; resuming completes the remaining phase length exactly.
- rst_n asserted asynchronously mid-period with N=65535 and pending=5 -> clk_out=0 immediately. After release: N=10, load_pend=0.
